// File: rtl/operand_fwd_stage.sv
// Registered ALU operand select: picks each operand from regfile, immediate, PC or the
// youngest matching in-flight result, and stalls decode on load-use hazards.

module operand_fwd_sel #(
  parameter int W    = 24,
  parameter int AW   = 4,
  parameter int NFWD = 2
) (
  input  logic [AW-1:0]      i_rs,
  input  logic [W-1:0]       i_rd,
  input  logic [NFWD-1:0]    i_fwd_valid,
  input  logic [NFWD*AW-1:0] i_fwd_addr,
  input  logic [NFWD*W-1:0]  i_fwd_data,
  output logic [W-1:0]       o_val
);
  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    o_val = i_rd;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_rs != '0 && i_fwd_valid[k] && i_fwd_addr[k*AW +: AW] == i_rs)
        o_val = i_fwd_data[k*W +: W];
    end
  end
endmodule

module operand_fwd_stage #(
  parameter int W        = 24,
  parameter int AW       = 4,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_rs1,
  input  logic [AW-1:0]      in_rs2,
  input  logic [AW-1:0]      in_rs3,
  input  logic [W-1:0]       in_rd1,
  input  logic [W-1:0]       in_rd2,
  input  logic [W-1:0]       in_rd3,
  input  logic [W-1:0]       in_imm,
  input  logic [W-1:0]       in_pc,
  input  logic               in_imm_src,
  input  logic               in_branch,
  input  logic               in_wr,
  input  logic [AW-1:0]      in_rd,
  input  logic               in_is_load,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*W-1:0]  fwd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_op1,
  output logic [W-1:0]       out_op2,
  output logic [W-1:0]       out_op3,
  output logic               out_wr,
  output logic [AW-1:0]      out_rd,
  output logic               out_is_load,
  output logic [15:0]        stall_cnt
);
  localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  logic               r_out_valid;
  logic [W-1:0]       r_op1, r_op2, r_op3;
  logic               r_out_wr, r_out_is_load;
  logic [AW-1:0]      r_out_rd;
  logic [AW-1:0]      r_pend_rd;
  logic [CW-1:0]      r_pend_cnt;
  logic [15:0]        r_stall_cnt;

  logic [2:0][AW-1:0] w_rs;
  logic [2:0][W-1:0]  w_rf;
  logic [2:0][W-1:0]  w_fv;
  logic [2:0]         w_used;
  logic [2:0]         w_haz;
  logic               w_hazard, w_ready, w_accept, w_handoff;

  assign w_rs   = {in_rs3, in_rs2, in_rs1};
  assign w_rf   = {in_rd3, in_rd2, in_rd1};
  assign w_used = {1'b1, !in_imm_src, !in_branch};

  for (genvar g = 0; g < 3; g++) begin : g_src
    operand_fwd_sel #(.W(W), .AW(AW), .NFWD(NFWD)) u_sel (
      .i_rs        (w_rs[g]),
      .i_rd        (w_rf[g]),
      .i_fwd_valid (fwd_valid),
      .i_fwd_addr  (fwd_addr),
      .i_fwd_data  (fwd_data),
      .o_val       (w_fv[g])
    );
    // A load still in the output register, or one whose result is not yet on a forward bus.
    assign w_haz[g] = w_used[g] && (w_rs[g] != '0) &&
                      ((r_out_valid && r_out_wr && r_out_is_load && r_out_rd == w_rs[g]) ||
                       ((r_pend_cnt != '0) && r_pend_rd == w_rs[g]));
  end

  assign w_hazard  = |w_haz;
  assign w_ready   = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && w_ready;
  assign w_handoff = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_op3         <= '0;
      r_out_wr      <= 1'b0;
      r_out_rd      <= '0;
      r_out_is_load <= 1'b0;
      r_pend_rd     <= '0;
      r_pend_cnt    <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (in_valid && w_hazard && !flush && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush) begin
        r_out_valid <= 1'b0;
        r_pend_cnt  <= '0;
      end else begin
        if (w_accept) begin
          r_out_valid   <= 1'b1;
          r_op1         <= in_branch  ? in_pc  : w_fv[0];
          r_op2         <= in_imm_src ? in_imm : w_fv[1];
          r_op3         <= w_fv[2];
          r_out_wr      <= in_wr;
          r_out_rd      <= in_rd;
          r_out_is_load <= in_is_load;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (w_handoff && r_out_wr && r_out_is_load) begin
          r_pend_rd  <= r_out_rd;
          r_pend_cnt <= CW'(LOAD_LAT);
        end else if (r_pend_cnt != '0) begin
          r_pend_cnt <= r_pend_cnt - 1'b1;
        end
      end
    end
  end

  assign in_ready    = w_ready;
  assign out_valid   = r_out_valid;
  assign out_op1     = r_op1;
  assign out_op2     = r_op2;
  assign out_op3     = r_op3;
  assign out_wr      = r_out_wr;
  assign out_rd      = r_out_rd;
  assign out_is_load = r_out_is_load;
  assign stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_operand_fwd_stage.sv
// Bench for operand_fwd_stage: a scoreboard holds expected operands per accepted
// instruction and is checked when the stage hands them to the ALU.

module tb_operand_fwd_stage;
  localparam int W = 24, AW = 4, NFWD = 2, LOAD_LAT = 2;

  logic              clk = 1'b0, rst_n, flush, in_valid, in_ready;
  logic [AW-1:0]     in_rs1, in_rs2, in_rs3, in_rd;
  logic [W-1:0]      in_rd1, in_rd2, in_rd3, in_imm, in_pc;
  logic              in_imm_src, in_branch, in_wr, in_is_load;
  logic [NFWD-1:0]   fwd_valid;
  logic [NFWD*AW-1:0] fwd_addr;
  logic [NFWD*W-1:0] fwd_data;
  logic              out_valid, out_ready, out_wr, out_is_load;
  logic [W-1:0]      out_op1, out_op2, out_op3;
  logic [AW-1:0]     out_rd;
  logic [15:0]       stall_cnt;

  int checks = 0, failures = 0;

  typedef struct packed {
    logic [W-1:0]  op1, op2, op3;
    logic          wr;
    logic [AW-1:0] rd;
    logic          ld;
  } exp_t;
  exp_t q[$];

  operand_fwd_stage #(.W(W), .AW(AW), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_rd3(in_rd3),
    .in_imm(in_imm), .in_pc(in_pc), .in_imm_src(in_imm_src), .in_branch(in_branch),
    .in_wr(in_wr), .in_rd(in_rd), .in_is_load(in_is_load),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3),
    .out_wr(out_wr), .out_rd(out_rd), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fv(input logic [AW-1:0] rs, input logic [W-1:0] rf);
    if (rs == 0) return rf;
    for (int k = 0; k < NFWD; k++)
      if (fwd_valid[k] && fwd_addr[k*AW +: AW] == rs) return fwd_data[k*W +: W];
    return rf;
  endfunction

  // Scoreboard: push on accept, pop on handoff; both sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e, g;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: output op1=%h with no expected entry", out_op1);
      end else begin
        e = q.pop_front();
        g = '{out_op1, out_op2, out_op3, out_wr, out_rd, out_is_load};
        if (g !== e) begin
          failures++;
          $display("FAIL sb_ops: got op1=%h op2=%h op3=%h wr=%b rd=%0d ld=%b exp op1=%h op2=%h op3=%h wr=%b rd=%0d ld=%b",
                   g.op1, g.op2, g.op3, g.wr, g.rd, g.ld, e.op1, e.op2, e.op3, e.wr, e.rd, e.ld);
        end
      end
    end
    if (rst_n && in_valid && in_ready) begin
      e.op1 = in_branch  ? in_pc  : fv(in_rs1, in_rd1);
      e.op2 = in_imm_src ? in_imm : fv(in_rs2, in_rd2);
      e.op3 = fv(in_rs3, in_rd3);
      e.wr = in_wr; e.rd = in_rd; e.ld = in_is_load;
      q.push_back(e);
    end
  end

  task automatic clear_in();
    in_valid = 0; flush = 0; out_ready = 1;
    in_rs1 = 0; in_rs2 = 0; in_rs3 = 0; in_rd = 0;
    in_rd1 = 24'h000111; in_rd2 = 24'h000222; in_rd3 = 24'h000333;
    in_imm = 24'h00ABCD; in_pc = 24'h001000;
    in_imm_src = 0; in_branch = 0; in_wr = 0; in_is_load = 0;
    fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    q.delete();
  endtask

  // Holds in_valid until accepted; returns how many cycles it waited.
  task automatic issue(output int stalls);
    stalls = 0;
    in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 50) begin
        checks++; failures++;
        $display("FAIL issue_timeout: in_ready stuck at %b, required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic set_load(input logic [AW-1:0] rd);
    clear_in();
    in_wr = 1; in_rd = rd; in_is_load = 1;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 0;
    in_valid = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if ({out_op1, out_op2, out_op3} !== '0) begin failures++; $display("FAIL reset_ops: got %h %h %h exp 0", out_op1, out_op2, out_op3); end
    checks++; if ({out_wr, out_rd, out_is_load} !== '0) begin failures++; $display("FAIL reset_dest: got wr=%b rd=%0d ld=%b exp 0", out_wr, out_rd, out_is_load); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
  endtask

  task automatic test_youngest();
    int s;
    do_reset();
    in_rs1 = 3; in_rs2 = 4; in_rs3 = 0;
    fwd_valid = 2'b11; fwd_addr = {4'd3, 4'd3}; fwd_data = {24'h000022, 24'h000011};
    issue(s);
    clear_in();
    @(negedge clk);
    checks++; if (out_op1 !== 24'h000011) begin failures++; $display("FAIL youngest_op1: got %h exp 000011", out_op1); end
    checks++; if (out_op2 !== 24'h000222) begin failures++; $display("FAIL youngest_op2: got %h exp 000222", out_op2); end
  endtask

  task automatic test_zero_and_mux();
    int s;
    do_reset();
    in_rs1 = 0; in_rd1 = 0; fwd_valid = 2'b01; fwd_addr = {4'd0, 4'd0}; fwd_data = {24'h0, 24'hFFFFFF};
    issue(s);
    @(negedge clk);
    checks++; if (out_op1 !== 24'h0) begin failures++; $display("FAIL zero_reg_op1: got %h exp 000000", out_op1); end
    clear_in();
    in_branch = 1; in_imm_src = 1; in_rs1 = 2; in_rs2 = 2;
    fwd_valid = 2'b01; fwd_addr = {4'd0, 4'd2}; fwd_data = {24'h0, 24'h777777};
    issue(s);
    @(negedge clk);
    checks++; if (out_op1 !== 24'h001000 || out_op2 !== 24'h00ABCD) begin
      failures++; $display("FAIL pc_imm_mux: got op1=%h op2=%h exp 001000 00ABCD", out_op1, out_op2);
    end
    clear_in();
  endtask

  task automatic test_load_use();
    int s;
    do_reset();
    set_load(5);
    issue(s);
    clear_in();
    in_rs2 = 5; fwd_valid = 2'b10; fwd_addr = {4'd5, 4'd0}; fwd_data = {24'h5A5A5A, 24'h0};
    issue(s);
    checks++; if (s != LOAD_LAT + 1) begin failures++; $display("FAIL load_use_stalls: got %0d exp %0d", s, LOAD_LAT + 1); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL load_use_stall_cnt: got %0d exp 3", stall_cnt); end
    checks++; if (out_op2 !== 24'h5A5A5A) begin failures++; $display("FAIL load_use_fwd: got %h exp 5A5A5A", out_op2); end
    clear_in();
  endtask

  task automatic test_imm_no_stall();
    int s;
    do_reset();
    set_load(5);
    issue(s);
    clear_in();
    in_imm_src = 1; in_rs2 = 5;
    issue(s);
    checks++; if (s != 0) begin failures++; $display("FAIL imm_no_stall: got %0d stalls exp 0", s); end
    clear_in();
  endtask

  task automatic test_backpressure();
    int s;
    do_reset();
    out_ready = 0;
    issue(s);
    in_rd1 = 24'h0BBBBB;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op1 !== 24'h000111) begin
        failures++; $display("FAIL bp_hold%0d: got ready=%b valid=%b op1=%h exp 0 1 000111", i, in_ready, out_valid, out_op1);
      end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL bp_stall_cnt: got %0d exp 0", stall_cnt); end
    out_ready = 1;
    issue(s);
    checks++; if (s != 0) begin failures++; $display("FAIL bp_release: got %0d stalls exp 0", s); end
    for (int i = 0; i < 3; i++) begin
      in_rd1 = 24'h00C000 + W'(i); in_rs3 = AW'(i + 1);
      fwd_valid = 2'b01; fwd_addr = {4'd0, AW'(i + 1)}; fwd_data = {24'h0, 24'h00D000 + W'(i)};
      issue(s);
      checks++; if (s != 0) begin failures++; $display("FAIL b2b_%0d: got %0d stalls exp 0", i, s); end
    end
    clear_in();
  endtask

  task automatic test_flush();
    int s;
    do_reset();
    set_load(5);
    issue(s);
    clear_in();
    @(posedge clk); #1;
    flush = 1; in_valid = 1; in_rs2 = 5;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b exp 0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL flush_stall_cnt: got %0d exp 0", stall_cnt); end
    @(posedge clk); #1;
    issue(s);
    checks++; if (s != 0) begin failures++; $display("FAIL flush_no_stall: got %0d stalls exp 0", s); end
    clear_in();
  endtask

  task automatic test_reset_mid_stall();
    int s;
    do_reset();
    set_load(7);
    issue(s);
    clear_in();
    in_rs1 = 7; in_valid = 1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL mid_stall_cnt: got %0d exp 2", stall_cnt); end
    rst_n = 0;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0 || {out_op1, out_op2, out_op3, out_rd} !== '0) begin
      failures++; $display("FAIL mid_stall_reset: got cnt=%0d valid=%b op1=%h rd=%0d exp all 0", stall_cnt, out_valid, out_op1, out_rd);
    end
    q.delete();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL sb_drain: %0d entries left exp 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_youngest();
    test_zero_and_mux();
    test_load_use();
    test_imm_no_stall();
    test_backpressure();
    test_drain();
    test_flush();
    test_drain();
    test_reset_mid_stall();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
